// File: rtl/soc.sv
// soc -- minimal single-hart RV32I system on one clock.
//
// A multicycle RV32I core with an on-chip RAM and one memory-mapped LED
// register. The board button resets the system and the six board LEDs are
// its only output.
//
// Parameters:
//   MEM_WORDS     RAM depth in 32-bit words (power of two)
//   MEM_INIT      name of the RAM image ("" = no image)
//   CLK_DIV_LOG2  width of the tick divider (slow-clock build only)
//
// Ports:
//   clk   in   system clock, rising edge
//   btn1  in   asynchronous active-low reset (0 = reset, 1 = run)
//   led   out  [5:0] active-low LEDs, led = ~led register
//
// Build option: define SOC_SLOW_CLK_EN to advance the FSM only on a 1-clk
// tick from a free-running CLK_DIV_LOG2-bit counter, so LED activity is
// visible on the board. Left undefined, the FSM advances every clk.
//
// Memory map: addr[22]=0 is RAM (word index addr[AW+1:2], upper bits alias),
// addr[22]=1 is I/O; the word with addr[2]=1 there is the LED register.

module soc #(
  parameter int    MEM_WORDS    = 256,
  parameter string MEM_INIT     = "firmware.hex",
  parameter int    CLK_DIV_LOG2 = 21
) (
  input  logic       clk,
  input  logic       btn1,
  output logic [5:0] led
);

  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_WAIT_I = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_LOAD   = 3'd4,
    S_WAIT_D = 3'd5,
    S_STORE  = 3'd6
  } state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_rs1_val;
  logic [31:0] r_rs2_val;
  logic [31:0] r_addr;
  logic [31:0] r_rdata;
  logic [5:0]  r_led;
  logic [31:0] r_regs [32];
  logic [31:0] r_mem  [MEM_WORDS];

  logic        w_tick;

  // ---------------------------------------------------------------- tick
`ifdef SOC_SLOW_CLK_EN
  logic [CLK_DIV_LOG2-1:0] r_div;

  always_ff @(posedge clk or negedge btn1) begin
    if (!btn1) r_div <= '0;
    else       r_div <= r_div + 1'b1;
  end

  assign w_tick = &r_div;
`else
  assign w_tick = 1'b1;
`endif

  // -------------------------------------------------------------- decode
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic        w_f7_alt;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_opcode = r_instr[6:0];
  assign w_rd     = r_instr[11:7];
  assign w_f3     = r_instr[14:12];
  assign w_rs1    = r_instr[19:15];
  assign w_rs2    = r_instr[24:20];
  assign w_f7_alt = r_instr[30];
  assign w_imm_i  = {{20{r_instr[31]}}, r_instr[31:20]};
  assign w_imm_s  = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
  assign w_imm_b  = {{19{r_instr[31]}}, r_instr[31], r_instr[7],
                     r_instr[30:25], r_instr[11:8], 1'b0};
  assign w_imm_u  = {r_instr[31:12], 12'b0};
  assign w_imm_j  = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12],
                     r_instr[20], r_instr[30:21], 1'b0};

  logic w_is_load, w_is_store;
  assign w_is_load  = (w_opcode == OPC_LOAD);
  assign w_is_store = (w_opcode == OPC_STORE);

  // ----------------------------------------------------------------- ALU
  logic [31:0] w_alu_b, w_alu;

  assign w_alu_b = (w_opcode == OPC_OP) ? r_rs2_val : w_imm_i;

  always_comb begin
    w_alu = 32'd0;
    case (w_f3)
      3'b000: w_alu = (w_opcode == OPC_OP && w_f7_alt) ? r_rs1_val - w_alu_b
                                                       : r_rs1_val + w_alu_b;
      3'b001: w_alu = r_rs1_val << w_alu_b[4:0];
      3'b010: w_alu = {31'd0, $signed(r_rs1_val) < $signed(w_alu_b)};
      3'b011: w_alu = {31'd0, r_rs1_val < w_alu_b};
      3'b100: w_alu = r_rs1_val ^ w_alu_b;
      3'b101: w_alu = w_f7_alt ? $unsigned($signed(r_rs1_val) >>> w_alu_b[4:0])
                               : r_rs1_val >> w_alu_b[4:0];
      3'b110: w_alu = r_rs1_val | w_alu_b;
      default: w_alu = r_rs1_val & w_alu_b;
    endcase
  end

  // ---------------------------------------------- branch / jump / result
  logic        w_taken;
  logic        w_wb_en;
  logic [31:0] w_exec_result;
  logic [31:0] w_pc_next;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_jalr_sum;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_jalr_sum = r_rs1_val + w_imm_i;

  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      3'b000: w_taken = (r_rs1_val == r_rs2_val);
      3'b001: w_taken = (r_rs1_val != r_rs2_val);
      3'b100: w_taken = ($signed(r_rs1_val) <  $signed(r_rs2_val));
      3'b101: w_taken = ($signed(r_rs1_val) >= $signed(r_rs2_val));
      3'b110: w_taken = (r_rs1_val <  r_rs2_val);
      3'b111: w_taken = (r_rs1_val >= r_rs2_val);
      default: w_taken = 1'b0;
    endcase
  end

  // Anything not listed (FENCE, SYSTEM, unknown) falls through as a NOP.
  always_comb begin
    w_exec_result = w_alu;
    w_wb_en       = 1'b0;
    w_pc_next     = w_pc_plus4;
    case (w_opcode)
      OPC_LUI:   begin w_exec_result = w_imm_u;        w_wb_en = 1'b1; end
      OPC_AUIPC: begin w_exec_result = r_pc + w_imm_u; w_wb_en = 1'b1; end
      OPC_JAL: begin
        w_exec_result = w_pc_plus4;
        w_wb_en       = 1'b1;
        w_pc_next     = r_pc + w_imm_j;
      end
      OPC_JALR: begin
        w_exec_result = w_pc_plus4;
        w_wb_en       = 1'b1;
        w_pc_next     = {w_jalr_sum[31:1], 1'b0};
      end
      OPC_BRANCH: if (w_taken) w_pc_next = r_pc + w_imm_b;
      OPC_OPIMM, OPC_OP: w_wb_en = 1'b1;
      default: ;
    endcase
  end

  // ------------------------------------------------------- load / store
  logic        w_is_io, w_is_led;
  logic [31:0] w_ld_raw, w_ld_data;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  assign w_is_io  = r_addr[22];
  assign w_is_led = r_addr[22] & r_addr[2];

  assign w_ld_raw  = w_is_io ? (w_is_led ? {26'd0, r_led} : 32'd0) : r_rdata;
  assign w_ld_byte = w_ld_raw[{r_addr[1:0], 3'b000} +: 8];
  assign w_ld_half = r_addr[1] ? w_ld_raw[31:16] : w_ld_raw[15:0];

  always_comb begin
    w_ld_data = w_ld_raw;
    case (w_f3)
      3'b000: w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001: w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100: w_ld_data = {24'd0, w_ld_byte};
      3'b101: w_ld_data = {16'd0, w_ld_half};
      default: w_ld_data = w_ld_raw;
    endcase
  end

  always_comb begin
    w_be = 4'b1111;
    case (w_f3)
      3'b000:  w_be = 4'b0001 << r_addr[1:0];
      3'b001:  w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Sub-word store data is replicated across lanes; byte enables pick the lane.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_wdata[gi*8 +: 8] =
          (w_f3 == 3'b000) ? r_rs2_val[7:0] :
          (w_f3 == 3'b001) ? r_rs2_val[(gi % 2)*8 +: 8] :
                             r_rs2_val[gi*8 +: 8];
    end
  endgenerate

  // ---------------------------------------------------------------- RAM
  logic [AW-1:0] w_mem_idx;
  logic          w_mem_we;

  // The data-phase states keep the data address on the port so a stalled
  // (slow-clock) FSM never sees r_rdata switch under it.
  assign w_mem_idx = (r_state == S_LOAD || r_state == S_WAIT_D || r_state == S_STORE)
                     ? r_addr[AW+1:2] : r_pc[AW+1:2];
  assign w_mem_we  = w_tick && (r_state == S_STORE) && !w_is_io;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_mem_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
      end
    end
    r_rdata <= r_mem[w_mem_idx];
  end

  // ------------------------------------------------------ register file
  logic        w_rf_we;
  logic [31:0] w_rf_wd;

  assign w_rf_we = w_tick && (w_rd != 5'd0) &&
                   ((r_state == S_EXEC && w_wb_en) || r_state == S_WAIT_D);
  assign w_rf_wd = (r_state == S_WAIT_D) ? w_ld_data : w_exec_result;

  always_ff @(posedge clk or negedge btn1) begin
    if (!btn1) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_rf_we) begin
      r_regs[w_rd] <= w_rf_wd;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge btn1) begin
    if (!btn1) r_state <= S_FETCH;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_tick) begin
      case (r_state)
        S_FETCH:  w_state_next = S_WAIT_I;
        S_WAIT_I: w_state_next = S_DECODE;
        S_DECODE: w_state_next = S_EXEC;
        S_EXEC:   w_state_next = w_is_load  ? S_LOAD  :
                                 w_is_store ? S_STORE : S_FETCH;
        S_LOAD:   w_state_next = S_WAIT_D;
        S_WAIT_D: w_state_next = S_FETCH;
        S_STORE:  w_state_next = S_FETCH;
        default:  w_state_next = S_FETCH;
      endcase
    end
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge btn1) begin
    if (!btn1) begin
      r_pc      <= '0;
      r_instr   <= '0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_addr    <= '0;
      r_led     <= '0;
    end else if (w_tick) begin
      case (r_state)
        S_WAIT_I: r_instr <= r_rdata;
        S_DECODE: begin
          r_rs1_val <= (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
          r_rs2_val <= (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
        end
        S_EXEC: begin
          r_pc   <= w_pc_next;
          r_addr <= r_rs1_val + (w_is_store ? w_imm_s : w_imm_i);
        end
        S_STORE: if (w_is_led) r_led <= r_rs2_val[5:0];
        default: ;
      endcase
    end
  end

  assign led = ~r_led;

  logic w_unused_addr;
  assign w_unused_addr = ^r_addr;

endmodule

// File: tb/tb_soc.sv
// tb_soc -- directed bench for soc. Small RV32I programs are written into
// the RAM while reset is held; the expected LED values for each program are
// queued at release and popped each time the LED port changes.

module tb_soc;

  logic       clk = 1'b0;
  logic       btn1;
  logic [5:0] led;

  int total = 0;
  int bad   = 0;

  logic [5:0]  sb_q[$];
  logic [31:0] prog[$];
  logic [5:0]  last_led;
  logic [2:0]  st;
  int          n;

  localparam logic [31:0] NOP = 32'h0000_0013;

  soc #(.MEM_WORDS(256), .MEM_INIT(""), .CLK_DIV_LOG2(4)) dut (
    .clk  (clk),
    .btn1 (btn1),
    .led  (led)
  );

  always #16 clk = ~clk;

  // ------------------------------------------------------ encoders
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [31:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'h13);
  endfunction

  // SW rs2, 4(x1): x1 always holds 0x0040_0000, so this hits the LED register
  function automatic logic [31:0] sw_led(input logic [4:0] rs2);
    return enc_s(32'd4, rs2, 5'd1, 3'b010);
  endfunction

  // ------------------------------------------------------ helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-12s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Holds reset, fills RAM with the current program (rest NOPs).
  task automatic reset_and_load();
    btn1 = 1'b0;
    for (int i = 0; i < 256; i++)
      dut.r_mem[i] = (i < prog.size()) ? prog[i] : NOP;
    repeat (3) @(negedge clk);
    last_led = led;
    sb_q.delete();
  endtask

  task automatic release_cpu();
    btn1 = 1'b1;
  endtask

  // Waits (bounded) for the LED port to change, then compares with the
  // oldest queued value. n returns the number of clk edges waited.
  task automatic expect_led(input string tag, input int budget, output int cnt);
    logic [5:0] exp;
    exp = sb_q.pop_front();
    cnt = 0;
    while (led === last_led && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    check(tag, {26'd0, led}, {26'd0, exp});
    last_led = led;
  endtask

  // ------------------------------------------------------ stimulus
  initial begin
    btn1 = 1'b0;

    // ---------------- 1: reset state and first LED write
    prog.delete();
    prog.push_back(enc_u(20'h00400, 5'd1, 7'h37));   // LUI  x1,0x400
    prog.push_back(addi(5'd2, 5'd0, 32'h15));        // ADDI x2,x0,0x15
    prog.push_back(sw_led(5'd2));                    // SW   x2,4(x1)
    prog.push_back(enc_j(32'd0, 5'd0));              // JAL  x0,0
    reset_and_load();
    st = dut.r_state;
    check("rst_led", {26'd0, led}, 32'h3F);
    check("rst_pc", dut.r_pc, 32'd0);
    check("rst_state", {29'd0, st}, 32'd0);
    release_cpu();
    sb_q.push_back(6'h2A);
    expect_led("led_wr", 40, n);
    check("led_wr_lat", n, 13);
    repeat (20) @(negedge clk);
    check("led_hold", {26'd0, led}, 32'h2A);

    // ---------------- 2: counter loop with 6-bit wrap
    prog.delete();
    prog.push_back(enc_u(20'h00400, 5'd1, 7'h37));   // LUI  x1,0x400
    prog.push_back(addi(5'd3, 5'd3, 32'd1));         // ADDI x3,x3,1
    prog.push_back(sw_led(5'd3));                    // SW   x3,4(x1)
    prog.push_back(enc_j(-32'sd8, 5'd0));            // JAL  x0,-8
    reset_and_load();
    release_cpu();
    for (int k = 1; k <= 66; k++) sb_q.push_back(~6'(k));
    for (int k = 1; k <= 66; k++) begin
      expect_led("cnt", 40, n);
      check("cnt_lat", n, 13);
    end

    // ---------------- 3: memory and ALU
    prog.delete();
    prog.push_back(enc_u(20'h00400, 5'd1, 7'h37));            // LUI  x1,0x400
    prog.push_back(addi(5'd5, 5'd0, 32'h100));                // x5 = 0x100
    prog.push_back(addi(5'd6, 5'd0, 32'h80));                 // x6 = 0x80
    prog.push_back(enc_s(32'd0, 5'd6, 5'd5, 3'b000));         // SB  x6,0(x5)
    prog.push_back(enc_i(32'd0, 5'd5, 3'b000, 5'd7, 7'h03));  // LB  x7,0(x5)
    prog.push_back(enc_i(32'd7, 5'd7, 3'b101, 5'd8, 7'h13));  // SRLI x8,x7,7
    prog.push_back(sw_led(5'd8));                             // led_q 3F
    prog.push_back(enc_i(32'd0, 5'd5, 3'b100, 5'd9, 7'h03));  // LBU x9,0(x5)
    prog.push_back(enc_i(32'd7, 5'd9, 3'b101, 5'd10, 7'h13)); // SRLI x10,x9,7
    prog.push_back(sw_led(5'd10));                            // led_q 01
    prog.push_back(addi(5'd12, 5'd0, -32'sd8));               // x12 = -8
    prog.push_back(enc_i(32'h401, 5'd12, 3'b101, 5'd13, 7'h13)); // SRAI x13,x12,1
    prog.push_back(sw_led(5'd13));                            // led_q 3C
    prog.push_back(enc_i(32'd26, 5'd13, 3'b101, 5'd14, 7'h13)); // SRLI x14,x13,26
    prog.push_back(sw_led(5'd14));                            // led_q 3F
    prog.push_back(addi(5'd15, 5'd0, 32'd1));                 // x15 = 1
    prog.push_back(addi(5'd16, 5'd0, -32'sd1));               // x16 = -1
    prog.push_back(enc_r(7'd0, 5'd16, 5'd15, 3'b011, 5'd17)); // SLTU x17
    prog.push_back(sw_led(5'd17));                            // led_q 01
    prog.push_back(enc_i(32'd4, 5'd1, 3'b010, 5'd19, 7'h03)); // LW  x19,4(x1)
    prog.push_back(addi(5'd19, 5'd19, 32'h10));               // x19 += 0x10
    prog.push_back(sw_led(5'd19));                            // led_q 11
    prog.push_back(enc_r(7'd0, 5'd16, 5'd15, 3'b010, 5'd18)); // SLT x18
    prog.push_back(sw_led(5'd18));                            // led_q 00
    prog.push_back(enc_j(32'd0, 5'd0));
    reset_and_load();
    release_cpu();
    sb_q.push_back(6'h00);
    sb_q.push_back(6'h3E);
    sb_q.push_back(6'h03);
    sb_q.push_back(6'h00);
    sb_q.push_back(6'h3E);
    sb_q.push_back(6'h2E);
    sb_q.push_back(6'h3F);
    expect_led("lb_sext", 60, n);
    expect_led("lbu_zext", 60, n);
    expect_led("srai", 60, n);
    expect_led("srai_fill", 60, n);
    expect_led("sltu", 60, n);
    expect_led("io_rd", 60, n);
    expect_led("slt", 60, n);

    // ---------------- 4: branches, JALR, x0
    prog.delete();
    prog.push_back(enc_u(20'h00400, 5'd1, 7'h37));            // 0  LUI x1
    prog.push_back(addi(5'd2, 5'd0, -32'sd1));                // 4  x2 = -1
    prog.push_back(addi(5'd3, 5'd0, 32'd1));                  // 8  x3 = 1
    prog.push_back(addi(5'd4, 5'd0, 32'h11));                 // 12 x4 = 0x11
    prog.push_back(enc_b(32'd8, 5'd3, 5'd2, 3'b100));         // 16 BLT  -> 24
    prog.push_back(addi(5'd4, 5'd0, 32'h22));                 // 20 skipped
    prog.push_back(sw_led(5'd4));                             // 24 led_q 11
    prog.push_back(enc_b(32'd8, 5'd3, 5'd2, 3'b110));         // 28 BLTU not taken
    prog.push_back(addi(5'd4, 5'd0, 32'h05));                 // 32 x4 = 5
    prog.push_back(sw_led(5'd4));                             // 36 led_q 05
    prog.push_back(addi(5'd5, 5'd0, 32'd57));                 // 40 x5 = 57
    prog.push_back(enc_i(32'd0, 5'd5, 3'b000, 5'd6, 7'h67));  // 44 JALR x6,0(x5)
    prog.push_back(addi(5'd4, 5'd0, 32'h0A));                 // 48 skipped
    prog.push_back(addi(5'd4, 5'd0, 32'h0B));                 // 52 skipped
    prog.push_back(enc_u(20'h00000, 5'd7, 7'h17));            // 56 AUIPC x7,0
    prog.push_back(sw_led(5'd7));                             // 60 led_q 38
    prog.push_back(sw_led(5'd6));                             // 64 led_q 30
    prog.push_back(addi(5'd0, 5'd0, 32'd5));                  // 68 ADDI x0,x0,5
    prog.push_back(sw_led(5'd0));                             // 72 led_q 00
    prog.push_back(enc_j(32'd0, 5'd0));                       // 76
    reset_and_load();
    release_cpu();
    sb_q.push_back(6'h2E);
    sb_q.push_back(6'h3A);
    sb_q.push_back(6'h07);
    sb_q.push_back(6'h0F);
    sb_q.push_back(6'h3F);
    expect_led("blt_taken", 60, n);
    expect_led("bltu_not", 60, n);
    expect_led("jalr_lsb", 60, n);
    expect_led("jalr_link", 60, n);
    expect_led("x0_zero", 60, n);

    // ---------------- 5: reset during the LED store
    prog.delete();
    prog.push_back(enc_u(20'h00400, 5'd1, 7'h37));
    prog.push_back(addi(5'd2, 5'd0, 32'h15));
    prog.push_back(sw_led(5'd2));
    prog.push_back(enc_j(32'd0, 5'd0));
    reset_and_load();
    release_cpu();
    @(negedge clk);
    st = dut.r_state;
    check("first_fetch", {29'd0, st}, 32'd1);
    repeat (11) @(negedge clk);
    st = dut.r_state;
    check("in_store", {29'd0, st}, 32'd6);
    btn1 = 1'b0;
    #1;
    st = dut.r_state;
    check("abort_pc", dut.r_pc, 32'd0);
    check("abort_state", {29'd0, st}, 32'd0);
    repeat (2) @(negedge clk);
    check("abort_led", {26'd0, led}, 32'h3F);
    last_led = led;
    release_cpu();
    sb_q.push_back(6'h2A);
    expect_led("restart", 40, n);
    check("restart_lat", n, 13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
